// File: rtl/sensor_conditioner.sv
// Loop-detector conditioning for the two-road traffic-light controller: sync, debounce,
// pending-request latch, stuck detect. Optional vehicle counters under `SENSOR_COUNT_EN.
module sensor_lane #(
  parameter int DEB_CYC   = 4,
  parameter int STUCK_CYC = 1000,
  parameter int CW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          raw,
  input  logic          gnt,
  output logic          s_req,
  output logic          fault,
  output logic [CW-1:0] cnt
);
  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int SW = $clog2(STUCK_CYC);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYC - 1);
  localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_CYC - 1);

  logic          s1, s2;
  logic          deb, deb_d;
  logic [DW-1:0] dcnt;
  logic          req;
  logic [SW-1:0] scnt;
  logic          rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Any return of s2 to the current debounced level restarts the stability count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb   <= 1'b0;
      dcnt  <= '0;
      deb_d <= 1'b0;
    end else begin
      deb_d <= deb;
      if (s2 == deb) begin
        dcnt <= '0;
      end else if (dcnt == DEB_MAX) begin
        deb  <= s2;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + DW'(1);
      end
    end
  end

  assign rise = deb & ~deb_d;

  // A car arriving on the same edge that green is reported keeps its request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req <= 1'b0;
    end else if (rise) begin
      req <= 1'b1;
    end else if (gnt) begin
      req <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scnt  <= '0;
      fault <= 1'b0;
    end else if (!deb) begin
      scnt <= '0;
    end else if (scnt == STUCK_MAX) begin
      fault <= 1'b1;
    end else begin
      scnt <= scnt + SW'(1);
    end
  end

`ifdef SENSOR_COUNT_EN
  logic [CW-1:0] vcnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vcnt <= '0;
    end else if (rise && (vcnt != {CW{1'b1}})) begin
      vcnt <= vcnt + CW'(1);
    end
  end

  assign cnt = vcnt;
`else
  assign cnt = '0;
`endif

  // Fault forces the request high so the controller keeps serving this road.
  assign s_req = deb | req | fault;
endmodule

module sensor_conditioner #(
  parameter int DEB_CYC   = 4,
  parameter int STUCK_CYC = 1000,
  parameter int CW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          raw_a,
  input  logic          raw_b,
  input  logic          gnt_a,
  input  logic          gnt_b,
  output logic          Sa,
  output logic          Sb,
  output logic          fault_a,
  output logic          fault_b,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_b
);
  sensor_lane #(.DEB_CYC(DEB_CYC), .STUCK_CYC(STUCK_CYC), .CW(CW)) u_lane_a (
    .clk   (clk),
    .reset (reset),
    .raw   (raw_a),
    .gnt   (gnt_a),
    .s_req (Sa),
    .fault (fault_a),
    .cnt   (cnt_a)
  );

  sensor_lane #(.DEB_CYC(DEB_CYC), .STUCK_CYC(STUCK_CYC), .CW(CW)) u_lane_b (
    .clk   (clk),
    .reset (reset),
    .raw   (raw_b),
    .gnt   (gnt_b),
    .s_req (Sb),
    .fault (fault_b),
    .cnt   (cnt_b)
  );
endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: per-cycle expected outputs queued at drive time and
// compared one edge later; counter expectations follow `SENSOR_COUNT_EN.
module tb_sensor_conditioner;
  localparam int DEB   = 4;
  localparam int STUCK = 20;
  localparam int CW    = 2;
  localparam int W     = 4 + 2 * CW;

  logic          clk = 1'b0;
  logic          reset;
  logic          raw_a, raw_b, gnt_a, gnt_b;
  logic          Sa, Sb, fault_a, fault_b;
  logic [CW-1:0] cnt_a, cnt_b;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  mon_e;
  int            n_cmp = 0;
  int            n_err = 0;

  logic          e_sa, e_sb, e_fa, e_fb;
  logic [CW-1:0] e_ca, e_cb;

  sensor_conditioner #(.DEB_CYC(DEB), .STUCK_CYC(STUCK), .CW(CW)) dut (
    .clk     (clk),
    .reset   (reset),
    .raw_a   (raw_a),
    .raw_b   (raw_b),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .Sa      (Sa),
    .Sb      (Sb),
    .fault_a (fault_a),
    .fault_b (fault_b),
    .cnt_a   (cnt_a),
    .cnt_b   (cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] bump(input logic [CW-1:0] c);
`ifdef SENSOR_COUNT_EN
    return (c == {CW{1'b1}}) ? c : CW'(c + 1'b1);
`else
    return (c & '0);
`endif
  endfunction

  // Drive one cycle of inputs; the e_* values describe the outputs after the coming edge.
  task automatic cyc(input logic ra, input logic rb, input logic ga, input logic gb);
    @(negedge clk);
    raw_a = ra;
    raw_b = rb;
    gnt_a = ga;
    gnt_b = gb;
    exp_q.push_back({e_sa, e_sb, e_fa, e_fb, e_ca, e_cb});
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_and_check(input string tag);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val({tag, "_Sa"}, Sa, 0);
    check_val({tag, "_Sb"}, Sb, 0);
    check_val({tag, "_fault_a"}, fault_a, 0);
    check_val({tag, "_fault_b"}, fault_b, 0);
    check_val({tag, "_cnt_a"}, cnt_a, 0);
    check_val({tag, "_cnt_b"}, cnt_b, 0);
    raw_a = 1'b0;
    raw_b = 1'b0;
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    {e_sa, e_sb, e_fa, e_fb} = 4'b0;
    e_ca = '0;
    e_cb = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check_val("Sa", Sa, mon_e[W-1]);
      check_val("Sb", Sb, mon_e[W-2]);
      check_val("fault_a", fault_a, mon_e[W-3]);
      check_val("fault_b", fault_b, mon_e[W-4]);
      check_val("cnt_a", cnt_a, mon_e[2*CW-1:CW]);
      check_val("cnt_b", cnt_b, mon_e[CW-1:0]);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    raw_a = 1'b0;
    raw_b = 1'b0;
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    reset_and_check("por");
    idle($urandom_range(2, 5));

    // Clean arrival on A: request at edge 5, latched at edge 6, cleared by green at 16.
    for (int i = 0; i < 18; i++) begin
      e_sa = (i >= 5) && (i < 16);
      if (i == 6) e_ca = bump(e_ca);
      cyc(i < 10, 1'b0, i == 16, 1'b0);
    end
    idle($urandom_range(2, 5));

    // Bounce: two bursts of DEB-1 stable cycles never reach the debounced level.
    for (int i = 0; i < 15; i++) begin
      cyc((i < 3) || ((i >= 4) && (i < 7)), 1'b0, 1'b0, 1'b0);
    end
    idle($urandom_range(2, 5));

    // Pending request on B outlives the car and clears one edge after green.
    for (int i = 0; i < 22; i++) begin
      e_sb = (i >= 5) && (i < 20);
      if (i == 6) e_cb = bump(e_cb);
      cyc(1'b0, i < 10, 1'b0, i == 20);
    end
    idle($urandom_range(2, 5));

    // Green on the very edge that latches the arrival: the request survives.
    for (int i = 0; i < 17; i++) begin
      e_sa = (i >= 5) && (i < 15);
      if (i == 6) e_ca = bump(e_ca);
      cyc(i < 6, 1'b0, (i == 6) || (i == 15), 1'b0);
    end
    idle($urandom_range(2, 5));

    // Stuck B sensor: fault after STUCK debounced-high cycles, Sb held through greens.
    for (int i = 0; i < 45; i++) begin
      e_sb = (i >= 5);
      e_fb = (i >= 25);
      if (i == 6) e_cb = bump(e_cb);
      cyc(1'b0, i < 30, 1'b0, (i == 38) || (i == 42));
    end
    idle($urandom_range(2, 5));

    // Partial debounce on A, then reset mid-count.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    reset_and_check("mid_rst");

    // Five arrivals after reset: counter starts from 0 and saturates.
    for (int a = 0; a < 5; a++) begin
      for (int i = 0; i < 14; i++) begin
        e_sa = (i >= 5) && (i < 13);
        if (i == 6) e_ca = bump(e_ca);
        cyc(i < 6, 1'b0, i == 13, 1'b0);
      end
    end
    idle(3);
    repeat (2) @(negedge clk);
    check_val("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
